note_priority_ctrl: RTL and testbench

Sequences the primary waveform generator from PS/2 key events. Sits between the keyboard decoder and waveform_gen. Keeps a last-note-priority stack of held keys and drives the active NOTE code, a gate (used as enable) and a one-cycle retrigger pulse. An optional hold timer keeps the gate open after the last key is released.

---
 rtl/note_priority_ctrl.sv | 143 ++++++++++++++
 tb/tb_note_priority_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_priority_ctrl.sv
// note_priority_ctrl: last-note-priority key stack driving the note, gate and
// retrigger inputs of the primary waveform generator, with an optional
// post-release hold timer.
module note_priority_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2500000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       key_release,
  output logic [4:0] note,
  output logic       gate,
  output logic       retrig,
  output logic [2:0] held_count,
  output logic       overflow
);

  localparam int unsigned HC_W = $clog2(DEPTH + 1);
  localparam logic [HC_W-1:0]  DEPTH_C = HC_W'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HOLD
  } state_t;

  state_t           state;
  logic [4:0]       stack     [DEPTH];
  logic [4:0]       stack_nxt [DEPTH];
  logic [HC_W-1:0]  count;
  logic [HC_W-1:0]  count_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             press_c;
  logic             release_c;
  logic             found;
  int               found_idx;
  logic             ovf_set;

  assign held_count = 3'(count);

  // Next stack contents and occupancy for the event presented this cycle
  always_comb begin
    press_c   = key_valid && (key_code != 5'd0) && !key_release;
    release_c = key_valid && (key_code != 5'd0) && key_release;
    found     = 1'b0;
    found_idx = 0;
    stack_nxt = stack;
    count_nxt = count;
    ovf_set   = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!found && (HC_W'(i) < count) && (stack[i] == key_code)) begin
        found     = 1'b1;
        found_idx = i;
      end
    end

    if (press_c) begin
      // Everything above the removed slot (or the whole stack) slides down one
      stack_nxt[0] = key_code;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stack_nxt[i] = (found && (i > found_idx)) ? stack[i] : stack[i-1];
      end
      if (!found) begin
        if (count == DEPTH_C) ovf_set = 1'b1;
        else                  count_nxt = count + 1'b1;
      end
    end else if (release_c && found) begin
      // Entries below the released slot close the gap
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (i >= found_idx) stack_nxt[i] = stack[i+1];
      end
      stack_nxt[DEPTH-1] = 5'd0;
      count_nxt          = count - 1'b1;
    end
  end

  // Stack registers, gate/retrig sequencing and hold timer
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) stack[i] <= 5'd0;
      count    <= '0;
      hold_cnt <= '0;
      note     <= 5'd0;
      gate     <= 1'b0;
      retrig   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      stack  <= stack_nxt;
      count  <= count_nxt;
      retrig <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
      // note tracks the top entry but freezes once the stack is empty
      if (count_nxt != '0) note <= stack_nxt[0];

      case (state)
        IDLE: begin
          if (press_c) begin
            state  <= PLAY;
            gate   <= 1'b1;
            retrig <= 1'b1;
          end
        end
        PLAY: begin
          if (count_nxt == '0) begin
            if (HOLD_CYCLES == 0) begin
              state <= IDLE;
              gate  <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_C;
            end
          end else if (press_c && (key_code != stack[0])) begin
            retrig <= 1'b1;
          end
        end
        HOLD: begin
          if (press_c) begin
            state    <= PLAY;
            retrig   <= 1'b1;
            hold_cnt <= '0;
          end else if (hold_cnt <= CNT_W'(1)) begin
            state    <= IDLE;
            gate     <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gate  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_priority_ctrl.sv
// tb_note_priority_ctrl: directed vector table plus randomized events checked
// against a queue-based reference model of the note priority controller.
module tb_note_priority_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 10;
  localparam int unsigned CW    = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_release;
  logic [4:0] note;
  logic       gate;
  logic       retrig;
  logic [2:0] held_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  note_priority_ctrl #(
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(HOLD),
    .CNT_W      (CW)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .note       (note),
    .gate       (gate),
    .retrig     (retrig),
    .held_count (held_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] code;
    logic       rel;
    logic [4:0] e_note;
    logic       e_gate;
    logic       e_retrig;
    logic [2:0] e_held;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: held keys newest-first in a queue
  int         q[$];
  logic [4:0] m_note;
  bit         m_gate;
  bit         m_retrig;
  bit         m_ovf;
  int         m_hold;

  function automatic void model_reset();
    q.delete();
    m_note   = 5'd0;
    m_gate   = 1'b0;
    m_retrig = 1'b0;
    m_ovf    = 1'b0;
    m_hold   = 0;
  endfunction

  function automatic void model_step(bit v, int c, bit r);
    bit press;
    bit rel;
    bit was_empty;
    int old_top;
    int idx;
    press     = v && (c != 0) && !r;
    rel       = v && (c != 0) && r;
    was_empty = (q.size() == 0);
    old_top   = was_empty ? -1 : q[0];
    idx       = -1;
    for (int i = 0; i < q.size(); i++) if (q[i] == c && idx < 0) idx = i;
    m_retrig = 1'b0;
    if (press) begin
      if (idx >= 0) q.delete(idx);
      else if (q.size() == int'(DEPTH)) begin
        void'(q.pop_back());
        m_ovf = 1'b1;
      end
      q.push_front(c);
      if (!m_gate || was_empty || c != old_top) m_retrig = 1'b1;
      m_gate = 1'b1;
    end else if (rel && idx >= 0) begin
      q.delete(idx);
      if (q.size() == 0) begin
        if (HOLD == 0) m_gate = 1'b0;
        else m_hold = HOLD;
      end
    end else if (m_gate && was_empty) begin
      if (m_hold <= 1) m_gate = 1'b0;
      else m_hold--;
    end
    if (q.size() > 0) m_note = 5'(q[0]);
  endfunction

  function automatic logic [10:0] dut_vec();
    return {note, gate, retrig, held_count, overflow};
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_note, m_gate, m_retrig, 3'(q.size()), m_ovf};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got note=%0d gate=%b retrig=%b held=%0d ovf=%b, want note=%0d gate=%b retrig=%b held=%0d ovf=%b",
               name, act[10:6], act[5], act[4], act[3:1], act[0],
               exp[10:6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  // Present one event for one clock edge; returns at the following negedge
  task automatic drive(input logic v, input logic [4:0] c, input logic r);
    key_valid   = v;
    key_code    = c;
    key_release = r;
    @(negedge clk);
    key_valid   = 1'b0;
    key_code    = 5'd0;
    key_release = 1'b0;
    model_step(v, int'(c), r);
  endtask

  function automatic vec_t mk(logic v, int c, logic r, int n, logic g, logic rt, int h, logic o);
    vec_t t;
    t.v = v; t.code = 5'(c); t.rel = r;
    t.e_note = 5'(n); t.e_gate = g; t.e_retrig = rt; t.e_held = 3'(h); t.e_ovf = o;
    return t;
  endfunction

  initial begin
    // Directed sequence: press/legato, ignored events, re-press, overflow, hold
    vecs.push_back(mk(1, 12, 0, 12, 1, 1, 1, 0));
    vecs.push_back(mk(0,  0, 0, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1,  7, 0,  7, 1, 1, 2, 0));
    vecs.push_back(mk(1,  7, 1, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1,  0, 0, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1, 20, 1, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1,  3, 0,  3, 1, 1, 2, 0));
    vecs.push_back(mk(1,  6, 0,  6, 1, 1, 3, 0));
    vecs.push_back(mk(1,  3, 0,  3, 1, 1, 3, 0));
    vecs.push_back(mk(1,  3, 1,  6, 1, 0, 2, 0));
    vecs.push_back(mk(1,  6, 1, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1, 12, 0, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1,  1, 0,  1, 1, 1, 2, 0));
    vecs.push_back(mk(1,  2, 0,  2, 1, 1, 3, 0));
    vecs.push_back(mk(1,  3, 0,  3, 1, 1, 4, 0));
    vecs.push_back(mk(1,  4, 0,  4, 1, 1, 4, 1));
    vecs.push_back(mk(1,  5, 0,  5, 1, 1, 4, 1));
    vecs.push_back(mk(1,  1, 1,  5, 1, 0, 4, 1));
    vecs.push_back(mk(1,  5, 1,  4, 1, 0, 3, 1));
    vecs.push_back(mk(1,  4, 1,  3, 1, 0, 2, 1));
    vecs.push_back(mk(1,  3, 1,  2, 1, 0, 1, 1));
    vecs.push_back(mk(1,  2, 1,  2, 1, 0, 0, 1));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 0, 0, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0,  0, 0,  2, 0, 0, 0, 1));
    vecs.push_back(mk(1,  9, 0,  9, 1, 1, 1, 1));
    vecs.push_back(mk(1,  9, 1,  9, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 9, 1, 0, 0, 1));
    vecs.push_back(mk(1,  9, 0,  9, 1, 1, 1, 1));
    vecs.push_back(mk(0,  0, 0,  9, 1, 0, 1, 1));
    vecs.push_back(mk(1,  9, 1,  9, 1, 0, 0, 1));
    vecs.push_back(mk(1,  9, 1,  9, 1, 0, 0, 1));

    resetn      = 1'b0;
    key_valid   = 1'b0;
    key_code    = 5'd0;
    key_release = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_vec(), 11'd0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].code, vecs[i].rel);
      check($sformatf("vec%0d", i), dut_vec(),
            {vecs[i].e_note, vecs[i].e_gate, vecs[i].e_retrig, vecs[i].e_held, vecs[i].e_ovf});
    end

    // Asynchronous reset in the middle of HOLD clears outputs before any edge
    resetn = 1'b0;
    #2;
    check("async_reset_in_hold", dut_vec(), 11'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check("after_reset_idle", dut_vec(), model_vec());

    // Randomized events against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic v;
      logic r;
      logic [4:0] c;
      v = ($urandom_range(0, 9) < 4);
      r = 1'($urandom_range(0, 1));
      c = 5'($urandom_range(0, 7));
      if ((n % 250) > 230) v = 1'b0;
      drive(v, c, r);
      check("random", dut_vec(), model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
